// File: rtl/seg_result_scan_if.sv
// rtl/seg_result_scan_if.sv - result/overflow input and display outputs of seg_result_scan
// Purpose: bundles the datapath result feeding the display stage together with the
//          multiplexed 7-segment outputs it drives.
// Signals:
//   result     4  signed two's-complement sum/difference (-8..+7)
//   overflow   1  add/sub overflow flag
//   seg        7  segments, active-low, seg[0]=a ... seg[6]=g
//   an         4  digit anodes, active-low
//   frame_tick 1  one-cycle pulse when a new snapshot is loaded
// Modports: master drives result/overflow and observes the display; slave is the scanner.
interface seg_result_scan_if;
  logic [3:0] result;
  logic       overflow;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output result,
    output overflow,
    input  seg,
    input  an,
    input  frame_tick
  );

  modport slave (
    input  result,
    input  overflow,
    output seg,
    output an,
    output frame_tick
  );
endinterface

// File: rtl/seg_result_scan.sv
// rtl/seg_result_scan.sv - 4-digit multiplexed 7-segment display of a signed add/sub result
// Purpose: registers the add/sub result every cycle, snapshots it once per full scan
//          so a frame never tears, and scans four digits: d0 magnitude, d1 sign,
//          d2 blank, d3 'F' on overflow.
// Ports:
//   clk    in  system clock, all logic on posedge
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of seg_result_scan_if (result/overflow in; seg/an/frame_tick out)
// Parameters:
//   REFRESH_DIV  clk cycles each digit is driven (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_DIV
module seg_result_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_result_scan_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIGIT_0 = 2'd0,
    DIGIT_1 = 2'd1,
    DIGIT_2 = 2'd2,
    DIGIT_3 = 2'd3
  } digit_e;

  logic [3:0]       in_res_q,   in_res_d;
  logic             in_ovf_q,   in_ovf_d;
  logic [3:0]       snap_res_q, snap_res_d;
  logic             snap_ovf_q, snap_ovf_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  digit_e           digit_q,    digit_d;
  logic [6:0]       seg_q,      seg_d;
  logic [3:0]       an_q,       an_d;
  logic             frame_tick_q, frame_tick_d;

  logic cnt_wrap;
  logic snap_load;

  // Segment pattern (g..a, active-low) for one digit of a given snapshot.
  function automatic logic [6:0] digit_pattern(input digit_e d,
                                               input logic [3:0] res,
                                               input logic ovf);
    logic [3:0] mag;
    logic [6:0] pat;
    // Negating 4'b1000 yields 4'b1000 again, which reads as 8.
    mag = res[3] ? (~res + 4'd1) : res;
    pat = SEG_BLANK;
    case (d)
      DIGIT_0: begin
        case (mag)
          4'd0:    pat = 7'b1000000;
          4'd1:    pat = 7'b1111001;
          4'd2:    pat = 7'b0100100;
          4'd3:    pat = 7'b0110000;
          4'd4:    pat = 7'b0011001;
          4'd5:    pat = 7'b0010010;
          4'd6:    pat = 7'b0000010;
          4'd7:    pat = 7'b1111000;
          4'd8:    pat = 7'b0000000;
          default: pat = SEG_BLANK;
        endcase
      end
      DIGIT_1: pat = res[3] ? 7'b0111111 : SEG_BLANK;
      DIGIT_2: pat = SEG_BLANK;
      DIGIT_3: pat = ovf ? 7'b0001110 : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  always_comb begin
    in_res_d   = bus.result;
    in_ovf_d   = bus.overflow;

    cnt_wrap   = (cnt_q == CNT_LAST);
    cnt_d      = cnt_wrap ? '0 : cnt_q + CNT_W'(1);

    digit_d    = digit_q;
    if (cnt_wrap) begin
      case (digit_q)
        DIGIT_0: digit_d = DIGIT_1;
        DIGIT_1: digit_d = DIGIT_2;
        DIGIT_2: digit_d = DIGIT_3;
        DIGIT_3: digit_d = DIGIT_0;
        default: digit_d = DIGIT_0;
      endcase
    end

    // A new snapshot is taken only at the end of the last digit of a frame.
    snap_load    = cnt_wrap && (digit_q == DIGIT_3);
    snap_res_d   = snap_load ? in_res_q : snap_res_q;
    snap_ovf_d   = snap_load ? in_ovf_q : snap_ovf_q;
    frame_tick_d = snap_load;

    // Outputs are built from the next digit and next snapshot so anode and
    // segments always change together on the same edge.
    an_d  = ~(4'b0001 << digit_d);
    seg_d = digit_pattern(digit_d, snap_res_d, snap_ovf_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_res_q     <= '0;
      in_ovf_q     <= 1'b0;
      snap_res_q   <= '0;
      snap_ovf_q   <= 1'b0;
      cnt_q        <= '0;
      digit_q      <= DIGIT_0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      in_res_q     <= in_res_d;
      in_ovf_q     <= in_ovf_d;
      snap_res_q   <= snap_res_d;
      snap_ovf_q   <= snap_ovf_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_result_scan.sv
// tb/tb_seg_result_scan.sv - self-checking bench for seg_result_scan
module tb_seg_result_scan;
  localparam int R  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_result_scan_if bus ();

  seg_result_scan #(.REFRESH_DIV(R), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Inputs seen at each edge since the last reset release, index = edge number.
  logic [4:0] hist[$];
  // Number of counter advances since reset release (= edges taken since release).
  int m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int digit, input logic [4:0] snap);
    int v;
    int mag;
    v   = int'($signed(snap[3:0]));
    mag = (v < 0) ? -v : v;
    case (digit)
      0: case (mag)
           0: return 7'b1000000;
           1: return 7'b1111001;
           2: return 7'b0100100;
           3: return 7'b0110000;
           4: return 7'b0011001;
           5: return 7'b0010010;
           6: return 7'b0000010;
           7: return 7'b1111000;
           default: return 7'b0000000;
         endcase
      1: return snap[3] ? 7'b0111111 : 7'b1111111;
      3: return snap[4] ? 7'b0001110 : 7'b1111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // One clock: drive inputs, take the edge, then compare against the frame model.
  task automatic cycle(input logic [3:0] res, input logic ovf, input logic rstn);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_tick;
    int         digit;
    int         lt;
    logic [4:0] snap;
    bus.result   = res;
    bus.overflow = ovf;
    rst_n        = rstn;
    @(posedge clk);
    if (!rstn) begin
      hist.delete();
      m      = 0;
      e_seg  = 7'b1111111;
      e_an   = 4'b1111;
      e_tick = 1'b0;
    end else begin
      hist.push_back({ovf, res});
      m++;
      digit  = (m / R) % 4;
      e_tick = ((m % (4 * R)) == 0);
      // Snapshot is the input present one edge before the most recent frame boundary.
      lt     = (m / (4 * R)) * (4 * R);
      snap   = (lt == 0) ? 5'd0 : hist[lt - 2];
      e_an   = ~(4'b0001 << digit);
      e_seg  = exp_seg(digit, snap);
    end
    @(negedge clk);
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
  endtask

  task automatic run(input logic [3:0] res, input logic ovf, input int n);
    for (int i = 0; i < n; i++) cycle(res, ovf, 1'b1);
  endtask

  initial begin
    logic [3:0] r;
    logic       o;
    bus.result   = 4'd0;
    bus.overflow = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) cycle(4'd0, 1'b0, 1'b0);

    run(4'b0011, 1'b0, 40);
    run(4'b1101, 1'b0, 32);
    run(4'b1000, 1'b0, 32);
    run(4'b0100, 1'b1, 32);
    run(4'b1111, 1'b1, 32);

    // Mid-frame change: hold 0010 across a frame boundary, then switch during digit 1.
    run(4'b0010, 1'b0, 20);
    for (int i = 0; i < 16 && ((m / R) % 4) != 1; i++) cycle(4'b0010, 1'b0, 1'b1);
    run(4'b0111, 1'b0, 40);

    // Reset pulse while digit 2 is lit.
    run(4'b0101, 1'b1, 5);
    for (int i = 0; i < 16 && ((m / R) % 4) != 2; i++) cycle(4'b0101, 1'b1, 1'b1);
    cycle(4'b0101, 1'b1, 1'b0);
    run(4'b0110, 1'b0, 50);

    r = 4'd0;
    o = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = 4'($urandom_range(0, 15));
        o = 1'($urandom_range(0, 1));
      end
      cycle(r, o, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
